seg7_share_ctrl: RTL



---
 rtl/seg7_pkg.sv | 46 ++++
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg7_share_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, state encoding and round-robin helper for the 8-digit
// 7-segment ownership controller (seg7_share_ctrl).
package seg7_pkg;

  localparam int NREQ = 3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} codes; entry n is the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_OPEN = 2'd2
  } state_e;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // First requesting index in the order ptr+1, ptr+2, ptr (mod NREQ).
  function automatic pick_t rr_pick(input logic [NREQ-1:0] req,
                                    input logic [1:0]      ptr);
    pick_t      r;
    logic [1:0] c;
    r.found = 1'b0;
    r.idx   = ptr;
    c       = ptr;
    for (int i = 0; i < NREQ; i++) begin
      c = (c == 2'(NREQ - 1)) ? 2'd0 : c + 2'd1;
      if (!r.found && req[c]) begin
        r.found = 1'b1;
        r.idx   = c;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment code.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/seg7_share_ctrl.sv
// Display-ownership controller: round-robin arbitration with minimum hold,
// owner data decode to eight digit buses. Optional blink: SEG7_BLINK_EN.
module seg7_share_ctrl
  import seg7_pkg::*;
#(
  parameter logic [23:0] HOLD_CYC  = 24'd10_000_000,
  parameter logic [23:0] BLINK_CYC = 24'd5_000_000
) (
  input  logic            iClk,
  input  logic            Reset,
  input  logic [NREQ-1:0] iReq,
  input  logic [31:0]     iData0,
  input  logic [31:0]     iData1,
  input  logic [31:0]     iData2,
  input  logic [7:0]      iBlank0,
  input  logic [7:0]      iBlank1,
  input  logic [7:0]      iBlank2,
  input  logic [7:0]      iBlink0,
  input  logic [7:0]      iBlink1,
  input  logic [7:0]      iBlink2,
  output logic [NREQ-1:0] oGnt,
  output logic            oBusy,
  output logic [6:0]      oSEG0,
  output logic [6:0]      oSEG1,
  output logic [6:0]      oSEG2,
  output logic [6:0]      oSEG3,
  output logic [6:0]      oSEG4,
  output logic [6:0]      oSEG5,
  output logic [6:0]      oSEG6,
  output logic [6:0]      oSEG7
);

  state_e          state, state_d;
  logic [23:0]     hold_cnt, hold_d;
  logic [1:0]      ptr, ptr_d;
  logic [NREQ-1:0] gnt, gnt_d;
  logic            load;
  logic            owner_req;
  logic [NREQ-1:0] others;
  pick_t           pick;

  assign owner_req = |(iReq & gnt);
  assign others    = iReq & ~gnt;
  assign pick      = rr_pick(iReq, ptr);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iClk or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      ptr      <= 2'd2;
      gnt      <= '0;
    end else begin
      state    <= state_d;
      hold_cnt <= hold_d;
      ptr      <= ptr_d;
      gnt      <= gnt_d;
    end
  end

  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state;
    hold_d  = hold_cnt;
    ptr_d   = ptr;
    gnt_d   = gnt;
    load    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pick.found) load = 1'b1;
      end
      ST_HOLD: begin
        if (!owner_req) begin
          if (pick.found) load = 1'b1;
          else            state_d = ST_IDLE;
        end else if (hold_cnt == '0) begin
          // Tenure served: behave as OPEN this cycle so the hold is exact.
          if (|others) load = 1'b1;
          else         state_d = ST_OPEN;
        end else begin
          hold_d = hold_cnt - 24'd1;
        end
      end
      ST_OPEN: begin
        if (!owner_req || (|others)) begin
          if (pick.found) load = 1'b1;
          else            state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE && !load) begin
      gnt_d  = '0;
      hold_d = '0;
    end
    if (load) begin
      gnt_d           = '0;
      gnt_d[pick.idx] = 1'b1;
      ptr_d           = pick.idx;
      hold_d          = HOLD_CYC - 24'd1;
      state_d         = ST_HOLD;
    end
  end

  logic [31:0] own_data;
  logic [7:0]  own_blank;
  logic [7:0]  own_blink;
  logic [7:0]  blink_mask;

  // With no owner every digit is forced dark through the blank mask.
  always_comb begin
    own_data  = '0;
    own_blank = '1;
    own_blink = '0;
    if (gnt[0]) begin
      own_data = iData0; own_blank = iBlank0; own_blink = iBlink0;
    end else if (gnt[1]) begin
      own_data = iData1; own_blank = iBlank1; own_blink = iBlink1;
    end else if (gnt[2]) begin
      own_data = iData2; own_blank = iBlank2; own_blink = iBlink2;
    end
  end

`ifdef SEG7_BLINK_EN
  logic [23:0] blink_cnt;
  logic        blink_dark;

  always_ff @(posedge iClk or negedge Reset) begin
    if (!Reset) begin
      blink_cnt  <= '0;
      blink_dark <= 1'b0;
    end else if (load) begin
      blink_cnt  <= '0;
      blink_dark <= 1'b0;
    end else if (blink_cnt == BLINK_CYC - 24'd1) begin
      blink_cnt  <= '0;
      blink_dark <= ~blink_dark;
    end else begin
      blink_cnt  <= blink_cnt + 24'd1;
    end
  end

  assign blink_mask = blink_dark ? own_blink : '0;
`else
  logic unused_blink;
  assign unused_blink = ^{own_blink, BLINK_CYC};
  assign blink_mask   = '0;
`endif

  logic [7:0][6:0] dec;
  logic [7:0][6:0] seg_d;
  logic [7:0][6:0] seg_q;

  for (genvar k = 0; k < 8; k++) begin : g_dec
    seg7_hex_decode u_dec (
      .nibble (own_data[4*k +: 4]),
      .seg    (dec[k])
    );
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      seg_d[k] = (own_blank[k] || blink_mask[k]) ? SEG_BLANK : dec[k];
    end
  end

  // NOTE: these digit registers drive outputs and must come up dark, so they are reset.
  always_ff @(posedge iClk or negedge Reset) begin
    if (!Reset) seg_q <= {8{SEG_BLANK}};
    else        seg_q <= seg_d;
  end

  assign oGnt  = gnt;
  assign oBusy = |gnt;
  assign oSEG0 = seg_q[0];
  assign oSEG1 = seg_q[1];
  assign oSEG2 = seg_q[2];
  assign oSEG3 = seg_q[3];
  assign oSEG4 = seg_q[4];
  assign oSEG5 = seg_q[5];
  assign oSEG6 = seg_q[6];
  assign oSEG7 = seg_q[7];

endmodule
